// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: FSM encoding and default sizes.
package perf_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 16;

    // Readout select width: ceil(log2(n)), never less than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 + (n == 2 ? 0 : 0) : $clog2(n);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// One event counter channel: live count, halt snapshot shadow and sticky overflow.
// Define PERF_SAT_EN to make the counter saturate at all-ones instead of wrapping.
module perf_counter
    import perf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             capture,
    output logic [CNT_W-1:0] live,
    output logic [CNT_W-1:0] shadow,
    output logic             ovf
);

    logic             at_max;
    logic [CNT_W-1:0] cnt_next;

    assign at_max = &live;

    always_comb begin
        cnt_next = live;
        if (inc) begin
`ifdef PERF_SAT_EN
            cnt_next = at_max ? live : live + CNT_W'(1);
`else
            cnt_next = live + CNT_W'(1);
`endif
        end
    end

    // The snapshot takes the post-increment value so the halting cycle's event is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live   <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
        end else if (clr) begin
            live   <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
        end else begin
            live <= cnt_next;
            if (inc && at_max) begin
                ovf <= 1'b1;
            end
            if (capture) begin
                shadow <= cnt_next;
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with a RUN/HALTED stop controller and snapshot readout.
// Saturating counters are selected by defining PERF_SAT_EN (see perf_counter).
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int SEL_W  = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] evt,
    input  logic              halt_req,
    input  logic              go,
    input  logic              clr,
    input  logic [SEL_W-1:0]  sel,
    output logic              run,
    output logic [CNT_W-1:0]  cnt_out,
    output logic [NUM_CH-1:0] ovf,
    output logic              snap_valid
);

    state_t           state;
    logic             capture;
    logic [CNT_W-1:0] live   [NUM_CH];
    logic [CNT_W-1:0] shadow [NUM_CH];

    assign run     = (state == RUN);
    assign capture = run && halt_req;

    // clr clears the snapshot flag but leaves the stop state alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            snap_valid <= 1'b0;
        end else begin
            case (state)
                RUN:     if (halt_req) state <= HALTED;
                HALTED:  if (go)       state <= RUN;
                default:               state <= RUN;
            endcase
            if (clr) begin
                snap_valid <= 1'b0;
            end else if (capture) begin
                snap_valid <= 1'b1;
            end else if (state == HALTED && go) begin
                snap_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        perf_counter #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .inc     (run && evt[i]),
            .capture (capture),
            .live    (live[i]),
            .shadow  (shadow[i]),
            .ovf     (ovf[i])
        );
    end

    // Selects beyond the last channel match no entry and read as zero.
    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(sel) == i) begin
                cnt_out = (state == HALTED) ? shadow[i] : live[i];
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed, table-driven bench for perf_counter_bank (8-bit counters, 4 channels plus a 3-channel instance).
module tb_perf_counter_bank;

    localparam logic [7:0] WRAP_EXP =
`ifdef PERF_SAT_EN
        8'd255;
`else
        8'd0;
`endif

    typedef struct {
        string      name;
        logic [3:0] evt;
        logic       halt_req;
        logic       go;
        logic       clr;
        logic [1:0] sel;
        int         reps;
        logic       exp_run;
        logic [7:0] exp_cnt;
        logic [3:0] exp_ovf;
        logic       exp_snap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] evt;
    logic       halt_req;
    logic       go;
    logic       clr;
    logic [1:0] sel;
    logic       run;
    logic [7:0] cnt_out;
    logic [3:0] ovf;
    logic       snap_valid;
    logic       run3;
    logic [7:0] cnt3;
    logic [2:0] ovf3;
    logic       snap3;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .evt(evt), .halt_req(halt_req), .go(go), .clr(clr),
        .sel(sel), .run(run), .cnt_out(cnt_out), .ovf(ovf), .snap_valid(snap_valid)
    );

    perf_counter_bank #(.NUM_CH(3), .CNT_W(8), .SEL_W(2)) dut3 (
        .clk(clk), .rst(rst), .evt(evt[2:0]), .halt_req(halt_req), .go(go), .clr(clr),
        .sel(sel), .run(run3), .cnt_out(cnt3), .ovf(ovf3), .snap_valid(snap3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_output(input string name, input logic e_run, input logic [7:0] e_cnt,
                                input logic [3:0] e_ovf, input logic e_snap);
        check({name, ".run"},  32'(run),        32'(e_run));
        check({name, ".cnt"},  32'(cnt_out),    32'(e_cnt));
        check({name, ".ovf"},  32'(ovf),        32'(e_ovf));
        check({name, ".snap"}, 32'(snap_valid), 32'(e_snap));
    endtask

    task automatic apply_stimulus(input vec_t v);
        evt      = v.evt;
        halt_req = v.halt_req;
        go       = v.go;
        clr      = v.clr;
        sel      = v.sel;
        repeat (v.reps) @(posedge clk);
        #1;
        check_output(v.name, v.exp_run, v.exp_cnt, v.exp_ovf, v.exp_snap);
    endtask

    task automatic add(input string n, input logic [3:0] e, input logic h, input logic g,
                       input logic c, input logic [1:0] s, input int r, input logic xr,
                       input logic [7:0] xc, input logic [3:0] xo, input logic xs);
        vecs.push_back('{n, e, h, g, c, s, r, xr, xc, xo, xs});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //   name        evt      h  g  c  sel  reps run cnt      ovf      snap
        add("count10",  4'b0001, 0, 0, 0, 2'd0, 10,  1, 8'd10,  4'b0000, 0);
        add("ch1to5",   4'b0010, 0, 0, 0, 2'd1, 5,   1, 8'd5,   4'b0000, 0);
        add("halt",     4'b0010, 1, 0, 0, 2'd1, 1,   0, 8'd6,   4'b0000, 1);
        add("frozen",   4'b0010, 0, 0, 0, 2'd1, 3,   0, 8'd6,   4'b0000, 1);
        add("shadow0",  4'b0000, 0, 0, 0, 2'd0, 1,   0, 8'd10,  4'b0000, 1);
        add("step_go",  4'b0011, 1, 1, 0, 2'd1, 1,   1, 8'd6,   4'b0000, 0);
        add("step_run", 4'b0011, 1, 0, 0, 2'd1, 1,   0, 8'd7,   4'b0000, 1);
        add("step_s0",  4'b0011, 1, 0, 0, 2'd0, 2,   0, 8'd11,  4'b0000, 1);
        add("shadow2",  4'b0000, 1, 0, 0, 2'd2, 1,   0, 8'd0,   4'b0000, 1);
        add("resume",   4'b0000, 0, 1, 0, 2'd0, 1,   1, 8'd11,  4'b0000, 0);
        add("to255",    4'b0100, 0, 0, 0, 2'd2, 255, 1, 8'd255, 4'b0000, 0);
        add("overflow", 4'b0100, 0, 0, 0, 2'd2, 1,   1, WRAP_EXP, 4'b0100, 0);
        add("sticky",   4'b0000, 0, 0, 0, 2'd2, 2,   1, WRAP_EXP, 4'b0100, 0);
        add("all4",     4'b1111, 0, 0, 0, 2'd3, 4,   1, 8'd4,   4'b0100, 0);
        add("clr_cap",  4'b1111, 1, 0, 1, 2'd3, 1,   0, 8'd0,   4'b0000, 0);
        add("no_recap", 4'b1111, 1, 0, 0, 2'd3, 1,   0, 8'd0,   4'b0000, 0);
        add("go2",      4'b0000, 0, 1, 0, 2'd3, 1,   1, 8'd0,   4'b0000, 0);
        add("all7",     4'b1111, 0, 0, 0, 2'd3, 7,   1, 8'd7,   4'b0000, 0);
        add("halt7",    4'b0000, 1, 0, 0, 2'd3, 1,   0, 8'd7,   4'b0000, 1);
        add("clr_halt", 4'b1111, 0, 0, 1, 2'd3, 1,   0, 8'd0,   4'b0000, 0);
        add("live_zero",4'b0000, 0, 1, 0, 2'd3, 1,   1, 8'd0,   4'b0000, 0);
        add("again7",   4'b1111, 0, 0, 0, 2'd3, 7,   1, 8'd7,   4'b0000, 0);
        add("halt_rst", 4'b0000, 1, 0, 0, 2'd3, 1,   0, 8'd7,   4'b0000, 1);

        rst = 1'b1; evt = '0; halt_req = 0; go = 0; clr = 0; sel = '0;
        #2;
        check_output("reset", 1'b1, 8'd0, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            if (vecs[i].name == "all4") begin
                check("sel_oob.cnt",  32'(cnt3),  32'd0);
                check("sel_oob.run",  32'(run3),  32'd1);
                check("sel_oob.ovf",  32'(ovf3),  32'b100);
                check("sel_oob.snap", 32'(snap3), 32'd0);
            end
        end

        // Asynchronous reset between edges while halted with counts of 7.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst", 1'b1, 8'd0, 4'b0000, 1'b0);
        halt_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("post_rst", 1'b1, 8'd0, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
